// File: rtl/hwpe_ctrl_job_offloader_if.sv
// Peripheral config-bus port of the HWPE job offloader: request/grant address phase
// plus a single-beat response phase.
interface hwpe_ctrl_job_offloader_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 16
);
    logic                  req;
    logic                  gnt;
    logic [ADDR_WIDTH-1:0] add;
    logic                  wen;
    logic [3:0]            be;
    logic [31:0]           data;
    logic [ID_WIDTH-1:0]   id;
    logic                  r_valid;
    logic [31:0]           r_data;

    modport master (
        output req, add, wen, be, data, id,
        input  gnt, r_valid, r_data
    );

    modport slave (
        input  req, add, wen, be, data, id,
        output gnt, r_valid, r_data
    );
endinterface

// File: rtl/hwpe_ctrl_job_offloader.sv
// Bus master that runs complete HWPE jobs: acquire a context, program the IO regs,
// trigger, wait for the end-of-job event and read FINISHED. One bus txn outstanding.
module hwpe_ctrl_job_offloader #(
    parameter int unsigned          N_IO_REGS   = 2,
    parameter int unsigned          ID_WIDTH    = 16,
    parameter int unsigned          ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int unsigned          IO_REG_IDX  = 16,
    parameter int unsigned          MASTER_ID   = 0,
    parameter int unsigned          BACKOFF_CYC = 8,
    parameter int unsigned          MAX_RETRY   = 255,
    parameter int unsigned          TIMEOUT_CYC = 0
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     job_valid_i,
    output logic                     job_ready_o,
    input  logic [32*N_IO_REGS-1:0]  job_params_i,
    output logic                     job_done_o,
    output logic [7:0]               job_id_o,
    output logic                     job_err_o,
    output logic                     busy_o,
    input  logic                     evt_i,
    hwpe_ctrl_job_offloader_if.master periph
);

    localparam int unsigned    KW     = $clog2(N_IO_REGS + 1);
    localparam logic [KW-1:0]  K_LAST = KW'(N_IO_REGS - 1);

    typedef enum logic [3:0] {
        IDLE, ACQ, BACKOFF, WR, TRIG, WAIT_EVT, FIN, DONE, ABORT
    } state_e;

    state_e state_q, state_d;

    logic                    req_q, out_q, wen_q;
    logic [ADDR_WIDTH-1:0]   add_q;
    logic [31:0]             data_q;
    logic [32*N_IO_REGS-1:0] params_q;
    logic [7:0]              job_id_q, retry_q, retry_inc;
    logic [31:0]             tmo_q, boff_q;
    logic [KW-1:0]           k_q;
    logic                    accept, resp, issue, acq_busy;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d     = state_q;
        job_ready_o = 1'b0;
        job_done_o  = 1'b0;
        job_err_o   = 1'b0;
        busy_o      = 1'b1;
        accept      = 1'b0;
        // A response counts only while we own the bus, so late or stray r_valid is dropped.
        resp        = periph.r_valid & (out_q | (req_q & periph.gnt));
        issue       = (state_q inside {ACQ, WR, TRIG, FIN}) & ~req_q & ~out_q;
        acq_busy    = periph.r_data[31];
        retry_inc   = retry_q + 8'd1;

        unique case (state_q)
            IDLE: begin
                job_ready_o = 1'b1;
                busy_o      = 1'b0;
                accept      = job_valid_i;
                if (job_valid_i) state_d = ACQ;
            end
            ACQ: if (resp) begin
                if (!acq_busy)                                             state_d = WR;
                else if (MAX_RETRY != 0 && retry_inc == 8'(MAX_RETRY))     state_d = ABORT;
                else                                                       state_d = BACKOFF;
            end
            BACKOFF:  if (boff_q == 32'(BACKOFF_CYC - 1)) state_d = ACQ;
            WR:       if (resp && k_q == K_LAST)           state_d = TRIG;
            TRIG:     if (resp)                            state_d = WAIT_EVT;
            WAIT_EVT: begin
                if (evt_i)                                                     state_d = FIN;
                else if (TIMEOUT_CYC != 0 && tmo_q == 32'(TIMEOUT_CYC - 1))    state_d = ABORT;
            end
            FIN:      if (resp) state_d = DONE;
            DONE: begin
                job_done_o = 1'b1;
                state_d    = IDLE;
            end
            ABORT: begin
                job_done_o = 1'b1;
                job_err_o  = 1'b1;
                state_d    = IDLE;
            end
            default:  state_d = IDLE;
        endcase

        if (clear_i) state_d = IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q    <= 1'b0;
            out_q    <= 1'b0;
            wen_q    <= 1'b1;
            add_q    <= '0;
            data_q   <= '0;
            params_q <= '0;
            job_id_q <= '0;
            retry_q  <= '0;
            tmo_q    <= '0;
            boff_q   <= '0;
            k_q      <= '0;
        end else if (clear_i) begin
            req_q    <= 1'b0;
            out_q    <= 1'b0;
            wen_q    <= 1'b1;
            add_q    <= '0;
            data_q   <= '0;
            params_q <= '0;
            job_id_q <= '0;
            retry_q  <= '0;
            tmo_q    <= '0;
            boff_q   <= '0;
            k_q      <= '0;
        end else begin
            // The ACQ read goes out straight from the accepting IDLE cycle to save a cycle.
            if (issue || accept) begin
                req_q <= 1'b1;
                unique case (state_q)
                    IDLE, ACQ: begin
                        add_q  <= BASE_ADDR + ADDR_WIDTH'(4);
                        wen_q  <= 1'b1;
                        data_q <= '0;
                    end
                    WR: begin
                        add_q  <= BASE_ADDR + ADDR_WIDTH'(4 * (IO_REG_IDX + 32'(k_q)));
                        wen_q  <= 1'b0;
                        data_q <= params_q[31:0];
                    end
                    TRIG: begin
                        add_q  <= BASE_ADDR;
                        wen_q  <= 1'b0;
                        data_q <= '0;
                    end
                    default: begin
                        add_q  <= BASE_ADDR + ADDR_WIDTH'(8);
                        wen_q  <= 1'b1;
                        data_q <= '0;
                    end
                endcase
            end else if (req_q && periph.gnt) begin
                req_q <= 1'b0;
            end

            if (resp)                       out_q <= 1'b0;
            else if (req_q && periph.gnt)   out_q <= 1'b1;

            if (accept) begin
                params_q <= job_params_i;
                retry_q  <= '0;
            end

            if (state_q == ACQ && resp) begin
                if (!acq_busy) begin
                    job_id_q <= periph.r_data[7:0];
                    k_q      <= '0;
                end else if (retry_q != 8'hFF) begin
                    retry_q  <= retry_inc;
                end
            end

            // Params drain through a shift register so the next write word is always at the bottom.
            if (state_q == WR && resp) begin
                k_q      <= k_q + KW'(1);
                params_q <= params_q >> 32;
            end

            boff_q <= (state_q == BACKOFF) ? boff_q + 32'd1 : 32'd0;

            if (state_q != WAIT_EVT)                              tmo_q <= '0;
            else if (TIMEOUT_CYC != 0 && tmo_q != 32'hFFFF_FFFF)  tmo_q <= tmo_q + 32'd1;

            if (state_d == ABORT) job_id_q <= 8'hFF;
        end
    end

    assign job_id_o       = job_id_q;
    assign periph.req     = req_q;
    assign periph.add     = add_q;
    assign periph.wen     = wen_q;
    assign periph.be      = 4'hF;
    assign periph.data    = data_q;
    assign periph.id      = ID_WIDTH'(MASTER_ID);

endmodule

// File: tb/tb_hwpe_ctrl_job_offloader.sv
// Randomized bench for hwpe_ctrl_job_offloader: a bus slave model records every
// transaction and a job-level reference model predicts the transaction list and result.
module tb_hwpe_ctrl_job_offloader;

    localparam int unsigned N     = 2;
    localparam int unsigned MAXR  = 4;
    localparam int unsigned TMO   = 100;
    localparam int unsigned BOFF  = 8;
    localparam int unsigned MID   = 16'h00A5;

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] data;
        int          rise;
        int          rv;
    } txn_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          job_valid = 1'b0;
    logic [63:0]   job_params = '0;
    logic          job_ready, job_done, job_err, busy;
    logic [7:0]    job_id;
    logic          evt = 1'b0;

    hwpe_ctrl_job_offloader_if #(.ADDR_WIDTH(32), .ID_WIDTH(16)) periph ();

    hwpe_ctrl_job_offloader #(
        .N_IO_REGS(N), .ID_WIDTH(16), .ADDR_WIDTH(32), .BASE_ADDR('0), .IO_REG_IDX(16),
        .MASTER_ID(MID), .BACKOFF_CYC(BOFF), .MAX_RETRY(MAXR), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .job_valid_i(job_valid), .job_ready_o(job_ready), .job_params_i(job_params),
        .job_done_o(job_done), .job_id_o(job_id), .job_err_o(job_err), .busy_o(busy),
        .evt_i(evt), .periph(periph)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Stimulus knobs, written only by the main process.
    logic [31:0] acq_model[$];
    int          gdly = 0;
    bit          no_evt = 1'b0;
    int          evt_dly = 0;
    int          job_seq = 0;
    int          stray_req = 0;

    // Slave/monitor state, written only by the slave process.
    int   cyc = 0;
    txn_t txns[$];
    txn_t cur;
    int   seen_seq = 0, acq_idx = 0, stray_ack = 0, cur_idx = 0, wcnt = 0;
    bit   in_req = 0, rsp_pend = 0, busy_slv = 0, trig_pend = 0, evt_arm = 0, prev_done = 0;
    logic [31:0] rsp_data = '0;
    int   evt_at = 0, proto_err = 0, done_cnt = 0, last_done_cyc = 0;
    logic last_err = 1'b0;
    logic [7:0] last_id = '0;

    // Reference-model outputs.
    txn_t exp_q[$];
    logic exp_err;
    logic [7:0] exp_id;
    int base_done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        bit was_busy;
        was_busy = busy_slv;
        if (seen_seq != job_seq) begin
            txns.delete();
            acq_idx  = 0;
            seen_seq = job_seq;
        end
        periph.gnt     = 1'b0;
        periph.r_valid = 1'b0;
        periph.r_data  = '0;
        if (rsp_pend) begin
            periph.r_valid = 1'b1;
            periph.r_data  = rsp_data;
            rsp_pend = 0;
            busy_slv = 0;
            if (cur_idx < txns.size()) txns[cur_idx].rv = cyc;
            if (trig_pend) begin
                evt_arm   = 1;
                evt_at    = cyc + evt_dly;
                trig_pend = 0;
            end
        end else if (stray_ack != stray_req) begin
            periph.r_valid = 1'b1;
            periph.r_data  = 32'h0000_0077;
            stray_ack = stray_req;
        end
        if (periph.req) begin
            if (!in_req) begin
                if (was_busy) proto_err++;
                if (periph.be != 4'hF || periph.id != 16'(MID)) proto_err++;
                in_req   = 1;
                wcnt     = 0;
                cur.addr = periph.add;
                cur.wen  = periph.wen;
                cur.data = periph.data;
                cur.rise = cyc;
                cur.rv   = -1;
            end else if (periph.add != cur.addr || periph.wen != cur.wen || periph.data != cur.data) begin
                proto_err++;
            end
            if (wcnt == gdly) begin
                periph.gnt = 1'b1;
                in_req   = 0;
                busy_slv = 1;
                rsp_pend = 1;
                txns.push_back(cur);
                cur_idx  = txns.size() - 1;
                if (cur.wen && cur.addr == 32'h4) begin
                    rsp_data = (acq_idx < acq_model.size()) ? acq_model[acq_idx] : 32'hFFFF_FFFF;
                    acq_idx++;
                end else begin
                    rsp_data = cur.wen ? 32'h0000_0001 : 32'h0;
                end
                if (!cur.wen && cur.addr == 32'h0) trig_pend = 1;
            end else begin
                wcnt++;
            end
        end else begin
            in_req = 0;
        end
        if (job_done) begin
            if (prev_done) proto_err++;
            done_cnt++;
            last_err      = job_err;
            last_id       = job_id;
            last_done_cyc = cyc;
            evt_arm       = 0;
        end
        prev_done = job_done;
        if (clear) begin
            evt_arm   = 0;
            trig_pend = 0;
        end
        evt = evt_arm && (cyc >= evt_at) && !no_evt;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Job-level model: which transactions a job must produce and how it must end.
    task automatic model();
        int tries;
        logic [31:0] r;
        tries = 0;
        exp_q.delete();
        exp_err = 1'b0;
        exp_id  = 8'hFF;
        forever begin
            r = (tries < acq_model.size()) ? acq_model[tries] : 32'hFFFF_FFFF;
            exp_q.push_back('{addr: 32'h4, wen: 1'b1, data: 32'h0, rise: 0, rv: 0});
            tries++;
            if (!r[31]) begin
                exp_id = r[7:0];
                break;
            end
            if (MAXR != 0 && tries == MAXR) begin
                exp_err = 1'b1;
                return;
            end
        end
        for (int k = 0; k < N; k++)
            exp_q.push_back('{addr: 32'h40 + 32'(4 * k), wen: 1'b0, data: job_params[32*k +: 32], rise: 0, rv: 0});
        exp_q.push_back('{addr: 32'h0, wen: 1'b0, data: 32'h0, rise: 0, rv: 0});
        if (no_evt) begin
            exp_err = 1'b1;
            exp_id  = 8'hFF;
            return;
        end
        exp_q.push_back('{addr: 32'h8, wen: 1'b1, data: 32'h0, rise: 0, rv: 0});
    endtask

    task automatic start_job(input logic [63:0] p, input int g, input bit ne, input int ed);
        int w;
        w = 0;
        while (!job_ready && w < 100) begin
            tick();
            w++;
        end
        check("ready_before_job", 32'(job_ready), 32'd1);
        gdly       = g;
        no_evt     = ne;
        evt_dly    = ed;
        job_seq    = job_seq + 1;
        job_params = p;
        job_valid  = 1'b1;
        base_done  = done_cnt;
        tick();
        job_valid = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
    endtask

    task automatic finish_job(input string name);
        int w;
        w = 0;
        while (done_cnt == base_done && w < 3000) begin
            tick();
            w++;
        end
        check({name, "_done_seen"}, 32'(done_cnt), 32'(base_done + 1));
        model();
        check({name, "_n_txn"}, 32'(txns.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < txns.size(); i++) begin
            check($sformatf("%s_addr%0d", name, i), txns[i].addr, exp_q[i].addr);
            check($sformatf("%s_wen%0d", name, i), 32'(txns[i].wen), 32'(exp_q[i].wen));
            if (!exp_q[i].wen) check($sformatf("%s_wdata%0d", name, i), txns[i].data, exp_q[i].data);
        end
        check({name, "_err"}, 32'(last_err), 32'(exp_err));
        check({name, "_id"}, 32'(last_id), 32'(exp_id));
        tick();
        tick();
        check({name, "_id_hold"}, 32'(job_id), 32'(exp_id));
        check({name, "_idle"}, 32'(busy), 32'd0);
        check({name, "_proto"}, 32'(proto_err), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int w;
        int trig_rv;
        logic [31:0] r;

        // Reset state
        repeat (3) tick();
        check("rst_req", 32'(periph.req), 32'd0);
        check("rst_wen", 32'(periph.wen), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rst_be", 32'(periph.be), 32'hF);
        check("rst_id", 32'(periph.id), 32'(MID));
        check("rst_done", 32'(job_done), 32'd0);
        check("rst_err", 32'(job_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_jobid", 32'(job_id), 32'd0);
        check("rst_addr", periph.add, 32'd0);

        // Straight job, grant same cycle
        acq_model = '{32'h0000_0003};
        start_job(64'hDEAD_BEEF_1234_5678, 0, 1'b0, 2);
        finish_job("t1");

        // Two busy answers, then success; check backoff gaps
        acq_model = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0005};
        start_job(64'h0BAD_F00D_CAFE_0001, 1, 1'b0, 0);
        finish_job("t2");
        for (int i = 0; i + 1 < txns.size(); i++)
            if (txns[i].addr == 32'h4 && txns[i+1].addr == 32'h4 && txns[i].wen && txns[i+1].wen)
                check("t2_backoff_gap", 32'((txns[i+1].rise - txns[i].rv - 1) >= int'(BOFF)), 32'd1);

        // Always busy: abort after MAX_RETRY reads
        acq_model.delete();
        start_job(64'h1111_2222_3333_4444, 0, 1'b0, 0);
        finish_job("t3");

        // Slow grants
        acq_model = '{32'h0000_0003};
        start_job(64'hDEAD_BEEF_1234_5678, 3, 1'b0, 5);
        finish_job("t4");

        // No event: timeout abort exactly after TMO cycles in WAIT_EVT
        acq_model = '{32'h0000_0007};
        start_job(64'h5555_6666_7777_8888, 0, 1'b1, 0);
        finish_job("t5");
        trig_rv = -1;
        foreach (txns[i]) if (!txns[i].wen && txns[i].addr == 32'h0) trig_rv = txns[i].rv;
        check("t5_timeout_cycles", 32'(last_done_cyc - trig_rv), 32'(TMO + 1));

        // Soft clear in the middle of the param writes
        acq_model = '{32'h0000_0009};
        start_job(64'hAAAA_BBBB_CCCC_DDDD, 0, 1'b0, 0);
        w = 0;
        while (w < 200) begin
            bit seen_wr;
            seen_wr = 0;
            foreach (txns[i]) if (!txns[i].wen) seen_wr = 1;
            if (seen_wr) break;
            tick();
            w++;
        end
        check("t6_reached_wr", 32'(w < 200), 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t6_clear_busy", 32'(busy), 32'd0);
        check("t6_clear_req", 32'(periph.req), 32'd0);
        tick();
        stray_req = stray_req + 1;
        repeat (4) tick();
        check("t6_stray_idle", 32'(busy), 32'd0);
        check("t6_no_done", 32'(done_cnt), 32'(base_done));
        acq_model = '{32'h0000_000C};
        start_job(64'h0102_0304_0506_0708, 0, 1'b0, 1);
        finish_job("t6");

        // Randomized jobs
        for (int j = 0; j < 16; j++) begin
            int nb;
            acq_model.delete();
            nb = ($urandom_range(0, 7) == 0) ? 6 : int'($urandom_range(0, 2));
            for (int b = 0; b < nb; b++)
                acq_model.push_back($urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'hFFFF_FFFE);
            r = $urandom;
            r[31] = 1'b0;
            acq_model.push_back(r);
            start_job({$urandom, $urandom}, int'($urandom_range(0, 3)),
                      ($urandom_range(0, 5) == 0), int'($urandom_range(0, 20)));
            finish_job($sformatf("rnd%0d", j));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
